// File: rtl/br_hazard_pkg.sv
// rtl/br_hazard_pkg.sv - shared types, select encoding and width helpers for br_hazard_unit
// Purpose: FSM state enum, register-file select code and width helper functions.
// Ports: none (package).
package br_hazard_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // Select value meaning "take the operand from the register file".
  localparam int SEL_RF = 0;

  function automatic int sel_width(input int num_fwd);
    return (num_fwd < 1) ? 1 : $clog2(num_fwd + 1);
  endfunction

  function automatic int idx_width(input int num_fwd);
    return (num_fwd < 2) ? 1 : $clog2(num_fwd);
  endfunction

  function automatic int cnt_width(input int ready_stg);
    return (ready_stg < 1) ? 1 : $clog2(ready_stg + 1);
  endfunction

endpackage

// File: rtl/br_hazard_unit_if.sv
// rtl/br_hazard_unit_if.sv - decoder-side bus of the ID-stage branch hazard unit
// Purpose: groups branch operand, pipeline destination and hazard control signals.
// Ports: master = pipeline side (drives i_*), slave = hazard unit (drives o_*).
interface br_hazard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 3,
  parameter int AW      = 5
);
  import br_hazard_pkg::*;

  localparam int SEL_W = sel_width(NUM_FWD);

  logic                     i_br_valid;
  logic [NUM_SRC*AW-1:0]    i_rs_addr;
  logic [NUM_FWD*AW-1:0]    i_stg_rdaddr;
  logic [NUM_FWD-1:0]       i_stg_rdwren;
  logic [NUM_FWD-1:0]       i_stg_ld;
  logic                     i_mispredict;
  logic [NUM_SRC*SEL_W-1:0] o_fwd_sel;
  logic                     o_stall;
  logic                     o_flush_ifid;
  logic [31:0]              o_stall_cycles;
  logic [15:0]              o_stall_events;

  modport master (
    output i_br_valid, i_rs_addr, i_stg_rdaddr, i_stg_rdwren, i_stg_ld, i_mispredict,
    input  o_fwd_sel, o_stall, o_flush_ifid, o_stall_cycles, o_stall_events
  );

  modport slave (
    input  i_br_valid, i_rs_addr, i_stg_rdaddr, i_stg_rdwren, i_stg_ld, i_mispredict,
    output o_fwd_sel, o_stall, o_flush_ifid, o_stall_cycles, o_stall_events
  );

endinterface

// File: rtl/br_fwd_match.sv
// rtl/br_fwd_match.sv - single-source priority forwarding matcher
// Purpose: finds the youngest downstream stage writing the source register.
// Ports: rs_addr_i, stg_rdaddr_i/stg_rdwren_i/stg_ld_i (per stage) in;
//        sel_o (0 = register file, k+1 = stage k), ld_o (winner is a load), idx_o (winner index) out.
module br_fwd_match
  import br_hazard_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int AW      = 5
) (
  input  logic [AW-1:0]                  rs_addr_i,
  input  logic [NUM_FWD*AW-1:0]          stg_rdaddr_i,
  input  logic [NUM_FWD-1:0]             stg_rdwren_i,
  input  logic [NUM_FWD-1:0]             stg_ld_i,
  output logic [sel_width(NUM_FWD)-1:0]  sel_o,
  output logic                           ld_o,
  output logic [idx_width(NUM_FWD)-1:0]  idx_o
);

  localparam int SEL_W = sel_width(NUM_FWD);
  localparam int IDX_W = idx_width(NUM_FWD);

  // Scan oldest to youngest so the lowest matching stage overwrites the rest.
  always_comb begin
    sel_o = SEL_W'(SEL_RF);
    ld_o  = 1'b0;
    idx_o = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (stg_rdwren_i[k] && (stg_rdaddr_i[k*AW +: AW] != '0) &&
          (stg_rdaddr_i[k*AW +: AW] == rs_addr_i)) begin
        sel_o = SEL_W'(k + 1);
        ld_o  = stg_ld_i[k];
        idx_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/br_hazard_unit.sv
// rtl/br_hazard_unit.sv - ID-stage branch forwarding, load-use stall and mispredict flush
// Purpose: drives branch-compare operand muxes, PC/IF-ID hold and IF/ID flush.
// Ports: i_clk, i_rst_n (async active-low); bus (br_hazard_unit_if.slave) carries
//        branch/operand/stage inputs and o_fwd_sel, o_stall, o_flush_ifid, stats outputs.
// Optional: BR_HAZARD_STATS_EN builds saturating stall cycle/event counters.
module br_hazard_unit
  import br_hazard_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD        = 3,
  parameter int AW             = 5,
  parameter int LOAD_READY_STG = 2
) (
  input logic              i_clk,
  input logic              i_rst_n,
  br_hazard_unit_if.slave  bus
);

  localparam int SEL_W = sel_width(NUM_FWD);
  localparam int IDX_W = idx_width(NUM_FWD);
  localparam int CNT_W = cnt_width(LOAD_READY_STG);

  logic [SEL_W-1:0]         sel_w [NUM_SRC];
  logic [IDX_W-1:0]         idx_w [NUM_SRC];
  logic [NUM_SRC-1:0]       ld_w;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_pack;
  logic [CNT_W-1:0]         need_v;
  logic [CNT_W-1:0]         n_max;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             stall_raw;
  logic             stall_o;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    br_fwd_match #(
      .NUM_FWD (NUM_FWD),
      .AW      (AW)
    ) u_match (
      .rs_addr_i    (bus.i_rs_addr[s*AW +: AW]),
      .stg_rdaddr_i (bus.i_stg_rdaddr),
      .stg_rdwren_i (bus.i_stg_rdwren),
      .stg_ld_i     (bus.i_stg_ld),
      .sel_o        (sel_w[s]),
      .ld_o         (ld_w[s]),
      .idx_o        (idx_w[s])
    );
  end

  always_comb begin
    fwd_sel_pack = '0;
    for (int s = 0; s < NUM_SRC; s++) fwd_sel_pack[s*SEL_W +: SEL_W] = sel_w[s];
  end
  assign bus.o_fwd_sel = fwd_sel_pack;

  // A load caught k stages downstream needs LOAD_READY_STG-k cycles before it can forward.
  always_comb begin
    n_max  = '0;
    need_v = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      need_v = '0;
      if (ld_w[s] && (int'(idx_w[s]) < LOAD_READY_STG))
        need_v = CNT_W'(LOAD_READY_STG - int'(idx_w[s]));
      if (need_v > n_max) n_max = need_v;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The flush cycle's IF/ID contents are dead, so no stall is raised for them.
        if (bus.i_br_valid && (n_max != '0) && !flush_q) begin
          stall_raw = 1'b1;
          cnt_d     = n_max - CNT_W'(1);
          if (n_max != CNT_W'(1)) state_d = STALL;
        end
      end
      STALL: begin
        stall_raw = 1'b1;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the hold low at once, even mid-stall.
  assign stall_o = stall_raw & i_rst_n;
  assign flush_d = bus.i_br_valid && bus.i_mispredict && !stall_o;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  assign bus.o_stall      = stall_o;
  assign bus.o_flush_ifid = flush_q;

`ifdef BR_HAZARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] stall_events_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cycles_q <= '0;
      stall_events_q <= '0;
    end else begin
      if (stall_o && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (stall_o && (state_q == IDLE) && (stall_events_q != '1))
        stall_events_q <= stall_events_q + 16'd1;
    end
  end

  assign bus.o_stall_cycles = stall_cycles_q;
  assign bus.o_stall_events = stall_events_q;
`else
  assign bus.o_stall_cycles = '0;
  assign bus.o_stall_events = '0;
`endif

endmodule

// File: doc/br_hazard_unit.md
# br_hazard_unit

Parametrised ID-stage branch hazard unit for the pipelined core. It generalises operand forwarding for the early branch comparator from a fixed two-stage, two-source scheme to NUM_SRC sources and NUM_FWD downstream stages. It adds a counter-driven load-use stall state machine and a registered IF/ID flush on branch mispredict. It sits beside the decoder, drives the branch-compare operand muxes, and drives the PC/IF-ID hold and flush controls.

## Interface
- NUM_SRC, 2, source operands checked per branch
- NUM_FWD, 3, downstream stages with a writeback destination; index 0 = ID/EX (youngest)
- AW, 5, register address width
- LOAD_READY_STG, 2, first stage index at which load data can be forwarded
- SEL_W, $clog2(NUM_FWD+1), localparam, select width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_br_valid  in  1  branch/jump-register instruction present in IF/ID
- i_rs_addr  in  NUM_SRC*AW  source register addresses, source s at bits [s*AW +: AW]
- i_stg_rdaddr  in  NUM_FWD*AW  destination address per stage
- i_stg_rdwren  in  NUM_FWD  destination write enable per stage
- i_stg_ld  in  NUM_FWD  stage holds a load
- i_mispredict  in  1  branch resolved in ID disagrees with prediction
- o_fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file, k = stage k-1
- o_stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- o_flush_ifid  out  1  kill IF/ID contents
- o_stall_cycles  out  32  total stall cycles (stats build only)
- o_stall_events  out  16  stall episodes (stats build only)

## Operation
- Match rules, per source s and stage k:
  - hit(s,k) = i_stg_rdwren[k] && i_stg_rdaddr[k]!=0 && i_rs_addr[s]==i_stg_rdaddr[k].
  - The lowest k with a hit wins. o_fwd_sel[s] = k+1, or 0 if there is no hit.
- Load wait:
  - need(s) = LOAD_READY_STG - k if the winning stage k has i_stg_ld set and k < LOAD_READY_STG; otherwise 0.
  - N = max over s of need(s). N is evaluated only when i_br_valid is high.
- FSM states:
  - IDLE → STALL when i_br_valid && N>0 && !o_flush_ifid. o_stall=1 combinationally in the detect cycle, and cnt loads N-1.
  - If N==1, the FSM stays in IDLE after the single stall cycle.
  - STALL: o_stall=1 and cnt decrements each cycle. The FSM returns to IDLE in the cycle cnt==0 is reached; that cycle still stalls.
  - After return to IDLE, operands are re-evaluated on the shifted pipeline state.
- In STALL, o_fwd_sel is don't-care, and i_br_valid and i_mispredict are ignored.
- Flush: o_flush_ifid is registered. It is set for exactly one cycle after a cycle with i_br_valid && i_mispredict && !o_stall.
- A flush cycle suppresses stall detection, because the IF/ID contents are dead. Flush therefore has priority over stall.
- Register x0 never matches.

## Timing
- Reset values: FSM = IDLE, cnt = 0, o_stall = 0, o_flush_ifid = 0, counters = 0. o_fwd_sel follows the inputs combinationally.
- Forwarding selects have zero-cycle latency.
- The first stall cycle is the detect cycle. Total stall length is exactly N cycles, with 1 ≤ N ≤ LOAD_READY_STG.
- Flush appears 1 cycle after the mispredict and lasts 1 cycle.
- Back-to-back mispredicts produce back-to-back flush pulses, each one cycle delayed.
- Reset asserted mid-stall forces IDLE immediately, with o_stall=0 asynchronously.
- cnt width is $clog2(LOAD_READY_STG+1).

## Configuration
- BR_HAZARD_STATS_EN defined:
  - o_stall_cycles increments on every cycle with o_stall=1.
  - o_stall_events increments on every IDLE→stall detection, including N==1 detections.
  - Both counters saturate at all-ones and reset to 0.
- BR_HAZARD_STATS_EN undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Shared package br_hazard_pkg:
  - FSM enum (IDLE, STALL)
  - select encoding constant SEL_RF = 0
  - width helper functions
- One sub-module, br_fwd_match: a single-source priority matcher. It takes NUM_FWD stage vectors and one address, and returns the select plus the winning stage's load flag and index.
- br_fwd_match is instantiated NUM_SRC times via generate.

## Test plan
- Forwarding, no stall (defaults): rs1=5 matches stage0 and stage1 (non-load), rs2=7 matches stage2 only → sel1=1, sel2=3, o_stall=0.
- Load two stages early: i_br_valid, rs1=4, stage0 rd=4 with ld=1 → o_stall high for exactly 2 cycles (detect cycle + 1), then low.
- Load one stage early: stage1 rd=4 with ld=1 → 1-cycle stall. Add rs2 matching a stage0 load in the same cycle → N=2.
- Zero register: rs1=0, stage0 rd=0 with wren=1 → sel=0, no stall.
- Mispredict collision: mispredict at cycle T → o_flush_ifid=1 at T+1 only. A load hazard presented at T+1 gives o_stall=0 at T+1.
- Reset during a 2-cycle stall → o_stall drops before the next clock edge; the stats counters read 0 after reset.
